ser2par_pingpong: RTL and testbench
===================================

SER2PAR_PINGPONG -- requirements
Module: ser2par_pingpong

Interface
REQ-001 Parameter DW, default 16: sample width in bits.
REQ-002 Parameter N, default 16: samples per frame; power of two, 4..64; LOG2N = log2(N).
REQ-003 Port clk  input  1: single clock; all state updates on rising edge.
REQ-004 Port rst  input  1: synchronous, active-low reset; sampled on rising clk.
REQ-005 Port in_d  input  DW: serial sample from FIR.
REQ-006 Port in_valid  input  1: in_d valid this cycle.
REQ-007 Port in_ready  output  1: block can accept a sample this cycle.
REQ-008 Port bitrev  input  1: lane-order mode; 0 = natural, 1 = bit-reversed.
REQ-009 Port par_d  output  N*DW: parallel frame; lane j occupies bits [j*DW+DW-1 : j*DW].
REQ-010 Port frame_valid  output  1: par_d holds a complete frame.
REQ-011 Port frame_ready  input  1: downstream (FFT) consumes the frame this cycle.
REQ-012 Port fill_cnt  output  LOG2N+1: samples held in the current fill bank, 0..N.

Function
REQ-013 Storage SHALL be two banks (A, B) of N x DW; one fill bank, one output bank, roles swapping per frame.
REQ-014 A sample is accepted iff in_valid && in_ready; no other condition writes storage.
REQ-015 in_ready SHALL be 1 iff the fill bank is not full (fill_cnt < N); it depends only on registered state, not on in_valid.
REQ-016 Accepted sample k of a frame (k = 0 first, 0..N-1) SHALL be written to lane k if the frame mode is 0, else to lane bitrev_LOG2N(k).
REQ-017 Frame mode SHALL be latched from bitrev on acceptance of sample k = 0; bitrev changes mid-frame have no effect until the next frame.
REQ-018 fill_cnt SHALL increment by 1 per accepted sample and wrap 0 after the Nth sample when a bank swap occurs.
REQ-019 Frame completion: acceptance of sample N-1 marks the fill bank full.
REQ-020 If the output bank is empty at completion, frame_valid SHALL rise on the next cycle (latency 1 cycle from the Nth accepted sample), banks swap, fill_cnt = 0, in_ready stays 1.
REQ-021 If the output bank is still occupied at completion, the full bank SHALL hold with fill_cnt = N and in_ready = 0 until the output frame is released.
REQ-022 A frame is released on frame_valid && frame_ready; frame_valid deasserts next cycle unless a full fill bank is waiting, in which case banks swap and frame_valid stays 1 with the new frame.
REQ-023 Simultaneous completion and release in one cycle: the completed frame SHALL appear on par_d next cycle with frame_valid continuously 1; no sample is lost or duplicated.
REQ-024 par_d SHALL be stable while frame_valid = 1 and frame_ready = 0.
REQ-025 par_d contents when frame_valid = 0 are don't-care; frame_valid SHALL never assert for a partial frame.
REQ-026 Sustained throughput SHALL be one sample per cycle when frame_ready is held 1.
REQ-027 Frames SHALL be emitted in acceptance order; data passes unmodified (no arithmetic, no sign change).
REQ-028 Full/empty summary: both banks empty -> frame_valid 0, in_ready 1; both full -> frame_valid 1, in_ready 0.

Reset
REQ-029 On rst = 0 at a rising edge: frame_valid = 0, fill_cnt = 0, in_ready = 1 next cycle, both banks empty, frame mode = 0.
REQ-030 Reset mid-frame or while a frame is pending SHALL discard all partial and pending data; par_d SHALL read 0 after reset.
REQ-031 in_valid and frame_ready are ignored while rst = 0.

Verification
REQ-032 N=16, DW=16, bitrev=0, samples 0x0000..0x000F on consecutive cycles, frame_ready=1 -> frame_valid for 1 cycle, one cycle after the 16th sample, lane j = j.
REQ-033 Same stimulus with bitrev=1 -> lane 1 = 0x0008, lane 8 = 0x0001, lane 15 = 0x000F, lane 0 = 0x0000.
REQ-034 frame_ready=0, 32 continuous samples -> first frame held stable; after the 32nd sample fill_cnt=16, in_ready=0; pulse frame_ready -> second frame presented next cycle, in_ready=1, fill_cnt=0.
REQ-035 frame_ready asserted in the same cycle sample 31 is accepted -> frame_valid stays 1 across the swap, second frame lanes = 16..31.
REQ-036 rst=0 after 7 accepted samples -> fill_cnt=0, frame_valid=0; next 16 samples form a complete frame with no residue of the first 7.
REQ-037 Random in_valid gaps and frame_ready backpressure over 1000 frames -> scoreboard matches every sample in order; no sample accepted while in_ready=0.

Source files
------------

// File: rtl/ser2par_pingpong.sv
// Serial-to-parallel frame builder with a fill bank and an output bank.
// A completed fill bank is handed to the output bank (par_d) when that bank is free.
module ser2par_pingpong #(
   parameter int unsigned DW = 16,
   parameter int unsigned N  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DW-1:0]         in_d,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  bitrev,
   output logic [N*DW-1:0]       par_d,
   output logic                  frame_valid,
   input  logic                  frame_ready,
   output logic [$clog2(N):0]    fill_cnt
);

   localparam int unsigned LOG2N = $clog2(N);
   localparam int unsigned CW    = LOG2N + 1;

   function automatic logic [LOG2N-1:0] rev_idx(input logic [LOG2N-1:0] x);
      logic [LOG2N-1:0] r;
      r = '0;
      for (int b = 0; b < int'(LOG2N); b++) begin
         r[b] = x[int'(LOG2N) - 1 - b];
      end
      return r;
   endfunction

   logic [DW-1:0]    bank_q [N];
   logic [DW-1:0]    bank_n [N];
   logic             mode_q;
   logic             mode_n;
   logic [N*DW-1:0]  par_n;
   logic             valid_n;
   logic             ready_n;
   logic [CW-1:0]    cnt_n;

   logic             accept;
   logic             mode_eff;
   logic [LOG2N-1:0] k;
   logic [LOG2N-1:0] lane;
   logic             fill_done;
   logic             out_free;

   // Next-state: write the incoming sample, then hand a full fill bank to the output when free
   always_comb begin
      bank_n    = bank_q;
      mode_n    = mode_q;
      par_n     = par_d;
      valid_n   = frame_valid && !frame_ready;
      cnt_n     = fill_cnt;
      accept    = in_valid && in_ready;
      k         = fill_cnt[LOG2N-1:0];
      mode_eff  = (fill_cnt == '0) ? bitrev : mode_q;
      lane      = mode_eff ? rev_idx(k) : k;
      out_free  = !frame_valid || frame_ready;

      if (accept) begin
         bank_n[lane] = in_d;
         cnt_n        = fill_cnt + CW'(1);
         if (fill_cnt == '0) begin
            mode_n = bitrev;
         end
      end

      // Completion this cycle, or a full bank already waiting for the output
      fill_done = (fill_cnt == CW'(N)) || (accept && (fill_cnt == CW'(N - 1)));

      if (fill_done && out_free) begin
         for (int j = 0; j < int'(N); j++) begin
            par_n[j*DW +: DW] = bank_n[j];
         end
         valid_n = 1'b1;
         cnt_n   = '0;
      end

      ready_n = (cnt_n != CW'(N));
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int j = 0; j < int'(N); j++) begin
            bank_q[j] <= '0;
         end
         mode_q      <= 1'b0;
         par_d       <= '0;
         frame_valid <= 1'b0;
         in_ready    <= 1'b1;
         fill_cnt    <= '0;
      end else begin
         bank_q      <= bank_n;
         mode_q      <= mode_n;
         par_d       <= par_n;
         frame_valid <= valid_n;
         in_ready    <= ready_n;
         fill_cnt    <= cnt_n;
      end
   end

endmodule

// File: tb/tb_ser2par_pingpong.sv
// Randomised and directed bench for ser2par_pingpong; a negedge monitor
// compares the DUT against a frame-level queue model.
module tb_ser2par_pingpong;

   localparam int unsigned DW    = 16;
   localparam int unsigned N     = 16;
   localparam int unsigned LOG2N = 4;
   localparam int unsigned FW    = N * DW;

   typedef logic [FW-1:0] frame_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [DW-1:0]    in_d;
   logic             in_valid;
   logic             in_ready;
   logic             bitrev;
   logic [FW-1:0]    par_d;
   logic             frame_valid;
   logic             frame_ready;
   logic [LOG2N:0]   fill_cnt;

   int total = 0;
   int bad   = 0;
   int released = 0;

   frame_t exp_q[$];
   frame_t cur = '0;
   int     cur_k = 0;
   logic   cur_mode = 1'b0;
   bit     zero_par = 1'b1;
   int     mon_lane;

   ser2par_pingpong #(.DW(DW), .N(N)) dut (
      .clk(clk), .rst(rst), .in_d(in_d), .in_valid(in_valid), .in_ready(in_ready),
      .bitrev(bitrev), .par_d(par_d), .frame_valid(frame_valid),
      .frame_ready(frame_ready), .fill_cnt(fill_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int rev(input int k);
      int r = 0;
      for (int b = 0; b < int'(LOG2N); b++) r = r * 2 + ((k >> b) & 1);
      return r;
   endfunction

   function automatic logic [DW-1:0] lane_of(input logic [FW-1:0] f, input int j);
      return f[j*DW +: DW];
   endfunction

   // Reference model: at most two completed frames are held (output + waiting fill bank)
   always @(negedge clk) begin
      check("frame_valid", FW'(frame_valid), FW'(exp_q.size() > 0));
      check("in_ready", FW'(in_ready), FW'(exp_q.size() < 2));
      check("fill_cnt", FW'(fill_cnt), FW'((exp_q.size() == 2) ? N : cur_k));
      if (exp_q.size() > 0) check("par_d", par_d, exp_q[0]);
      else if (zero_par) check("par_d_zero", par_d, '0);

      if (!rst) begin
         exp_q.delete();
         cur      = '0;
         cur_k    = 0;
         cur_mode = 1'b0;
         zero_par = 1'b1;
      end else begin
         if (frame_valid && frame_ready) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            released++;
         end
         if (in_valid && in_ready) begin
            if (cur_k == 0) cur_mode = bitrev;
            mon_lane = cur_mode ? rev(cur_k) : cur_k;
            cur[mon_lane*DW +: DW] = in_d;
            cur_k++;
            if (cur_k == int'(N)) begin
               exp_q.push_back(cur);
               cur_k    = 0;
               zero_par = 1'b0;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_burst(input int base, input int cnt, input bit ready_on_last);
      for (int i = 0; i < cnt; i++) begin
         in_valid = 1'b1;
         in_d     = DW'(base + i);
         if (ready_on_last && i == cnt - 1) frame_ready = 1'b1;
         step();
      end
      in_valid = 1'b0;
   endtask

   initial begin
      int base_rel;
      int cyc;
      int rp;

      rst = 1'b0; in_valid = 1'b0; in_d = '0; bitrev = 1'b0; frame_ready = 1'b0;
      repeat (2) step();
      check("reset_cnt", FW'(fill_cnt), '0);
      check("reset_ready", FW'(in_ready), FW'(1));
      rst = 1'b1;
      step();

      // Natural order, consumer always ready
      frame_ready = 1'b1; bitrev = 1'b0;
      send_burst(0, 16, 1'b0);
      check("nat_valid", FW'(frame_valid), FW'(1));
      check("nat_lane3", FW'(lane_of(par_d, 3)), FW'(3));
      check("nat_lane15", FW'(lane_of(par_d, 15)), FW'(15));
      step();
      check("nat_pulse", FW'(frame_valid), '0);

      // Bit-reversed order
      bitrev = 1'b1;
      send_burst(0, 16, 1'b0);
      bitrev = 1'b0;
      check("rev_lane0", FW'(lane_of(par_d, 0)), FW'(16'h0000));
      check("rev_lane1", FW'(lane_of(par_d, 1)), FW'(16'h0008));
      check("rev_lane8", FW'(lane_of(par_d, 8)), FW'(16'h0001));
      check("rev_lane15", FW'(lane_of(par_d, 15)), FW'(16'h000F));
      step();

      // Backpressure: both banks fill, then one release
      frame_ready = 1'b0;
      send_burst(16'h100, 32, 1'b0);
      check("bp_cnt", FW'(fill_cnt), FW'(16));
      check("bp_ready", FW'(in_ready), '0);
      check("bp_hold", FW'(lane_of(par_d, 0)), FW'(16'h100));
      frame_ready = 1'b1;
      step();
      frame_ready = 1'b0;
      check("bp_swap_lane0", FW'(lane_of(par_d, 0)), FW'(16'h110));
      check("bp_swap_ready", FW'(in_ready), FW'(1));
      check("bp_swap_cnt", FW'(fill_cnt), '0);
      frame_ready = 1'b1;
      step();

      // Completion and release in the same cycle
      frame_ready = 1'b0;
      send_burst(0, 32, 1'b1);
      check("sim_valid", FW'(frame_valid), FW'(1));
      check("sim_lane0", FW'(lane_of(par_d, 0)), FW'(16));
      check("sim_lane15", FW'(lane_of(par_d, 15)), FW'(31));
      step();
      check("sim_drop", FW'(frame_valid), '0);

      // Reset in the middle of a frame
      send_burst(16'h300, 7, 1'b0);
      rst = 1'b0;
      step();
      rst = 1'b1;
      check("mid_rst_cnt", FW'(fill_cnt), '0);
      check("mid_rst_valid", FW'(frame_valid), '0);
      check("mid_rst_par", par_d, '0);
      send_burst(16'h400, 16, 1'b0);
      check("mid_rst_lane0", FW'(lane_of(par_d, 0)), FW'(16'h400));
      check("mid_rst_lane6", FW'(lane_of(par_d, 6)), FW'(16'h406));
      step();

      // Random traffic with varying backpressure
      base_rel = released;
      cyc = 0;
      rp = 50;
      while ((released - base_rel) < 1000 && cyc < 80000) begin
         if (cyc % 256 == 0) rp = (cyc / 256) % 3 == 0 ? 10 : ((cyc / 256) % 3 == 1 ? 50 : 100);
         in_valid    = ($urandom_range(0, 99) < 75);
         in_d        = DW'($urandom);
         bitrev      = 1'($urandom_range(0, 1));
         frame_ready = ($urandom_range(0, 99) < rp);
         step();
         cyc++;
      end
      check("rand_frames", FW'((released - base_rel) >= 1000), FW'(1));

      in_valid = 1'b0; frame_ready = 1'b1;
      repeat (4) step();
      check("drain_valid", FW'(frame_valid), '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
